// File: rtl/fifo_wr_arbiter_if.sv
// Producer-side write bus shared by NUM_REQ requesters and the FIFO write port.
// The slave modport belongs to the arbiter; the master modport belongs to producers and the FIFO model.
interface fifo_wr_arbiter_if #(
  parameter int data_width = 8,
  parameter int NUM_REQ    = 4
);
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*data_width-1:0] req_data;
  logic                          full;
  logic [NUM_REQ-1:0]            ack;
  logic [NUM_REQ-1:0]            grant;
  logic                          w_en;
  logic [data_width-1:0]         data_in;

  modport master (
    output req, req_data, full,
    input  ack, grant, w_en, data_in
  );

  modport slave (
    input  req, req_data, full,
    output ack, grant, w_en, data_in
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-bounded arbiter for the async-FIFO write port (FIFO_WR_ARB_STALL_CNT_EN adds stall_cnt).
// Latency: grant one cycle after req in IDLE; owner handover is bubble-free; w_en/ack/data_in are combinational.
// Backpressure: full stalls the owner in place (no ack, beat count and ownership hold, no timeout).
module fifo_wr_arbiter #(
  parameter int data_width = 8,
  parameter int NUM_REQ    = 4,
  parameter int MAX_BURST  = 4
) (
  input  logic             w_clk,
  input  logic             wrst_n,
  fifo_wr_arbiter_if.slave wr
`ifdef FIFO_WR_ARB_STALL_CNT_EN
  ,
  output logic [15:0]      stall_cnt
`endif
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST) + 1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                state, state_nxt;
  logic [IDX_W-1:0]      owner, owner_nxt;
  logic [IDX_W-1:0]      last_owner, last_owner_nxt;
  logic [CNT_W-1:0]      beat_cnt, beat_cnt_nxt;

  logic [NUM_REQ-1:0]    own_oh;
  logic                  own_req;
  logic                  accept;
  logic                  last_beat;
  logic                  release_own;
  logic [NUM_REQ-1:0]    arb_mask;
  logic [IDX_W-1:0]      arb_base;
  logic [IDX_W-1:0]      arb_idx;
  logic                  arb_found;
  logic [data_width-1:0] own_dat;

  // First set bit of mask strictly after base, wrapping; MSB of the result flags a hit.
  function automatic logic [IDX_W:0] rr_pick(input logic [NUM_REQ-1:0] mask,
                                             input logic [IDX_W-1:0]   base);
    logic [IDX_W:0] res;
    int             idx;
    res = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = int'(base) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (mask[IDX_W'(idx)]) res = {1'b1, IDX_W'(idx)};
    end
    return res;
  endfunction

  assign own_oh      = NUM_REQ'(1) << owner;
  assign own_req     = |(wr.req & own_oh);
  assign accept      = (state == GRANT) && own_req && !wr.full;
  assign last_beat   = accept && (beat_cnt == CNT_W'(MAX_BURST - 1));
  assign release_own = (state == GRANT) && (last_beat || !own_req);

  // On handover the outgoing owner is masked so it cannot win its own release.
  assign arb_mask = (state == GRANT) ? (wr.req & ~own_oh) : wr.req;
  assign arb_base = (state == GRANT) ? owner : last_owner;
  assign {arb_found, arb_idx} = rr_pick(arb_mask, arb_base);

  always_comb begin
    own_dat = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (own_oh[i]) own_dat = wr.req_data[i*data_width +: data_width];
    end
  end

  assign wr.grant   = (state == GRANT) ? own_oh : '0;
  assign wr.w_en    = accept;
  assign wr.ack     = accept ? own_oh : '0;
  assign wr.data_in = accept ? own_dat : '0;

  always_comb begin
    state_nxt      = state;
    owner_nxt      = owner;
    last_owner_nxt = last_owner;
    beat_cnt_nxt   = beat_cnt;
    case (state)
      IDLE: begin
        if (arb_found) begin
          state_nxt    = GRANT;
          owner_nxt    = arb_idx;
          beat_cnt_nxt = '0;
        end
      end
      GRANT: begin
        if (accept) beat_cnt_nxt = beat_cnt + CNT_W'(1);
        if (release_own) begin
          last_owner_nxt = owner;
          beat_cnt_nxt   = '0;
          if (arb_found) owner_nxt = arb_idx;
          else           state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge w_clk) begin
    if (!wrst_n) begin
      state      <= IDLE;
      owner      <= '0;
      last_owner <= IDX_W'(NUM_REQ - 1);
      beat_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      last_owner <= last_owner_nxt;
      beat_cnt   <= beat_cnt_nxt;
    end
  end

`ifdef FIFO_WR_ARB_STALL_CNT_EN
  always_ff @(posedge w_clk) begin
    if (!wrst_n) begin
      stall_cnt <= '0;
    end else if ((state == GRANT) && own_req && wr.full && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule
